// File: rtl/alu_pkg.sv
// Shared definitions for the parametrised sequential ALU.
// Holds op codes, FSM state encoding, iteration modes and done-cycle latencies.
// No logic of its own; imported by the controller and the step unit.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_Y   = 3'd1,
        S_ADDSUB   = 3'd2,
        S_MUL_STEP = 3'd3,
        S_DIV_STEP = 3'd4,
        S_DIV_FIX  = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    typedef enum logic {
        STEP_BOOTH = 1'b0,
        STEP_DIV   = 1'b1
    } step_mode_t;

    // Cycle (counting the start-sampling edge as cycle 0) in which done is high.
    localparam int LAT_ADDSUB = 3;
    localparam int LAT_DIV0   = 3;

    function automatic int lat_mul(input int width);
        return width + 3;
    endfunction

    function automatic int lat_div(input int width);
        return width + 4;
    endfunction

endpackage

// File: rtl/alu_step_unit.sv
// One Booth-multiply or non-restoring-divide iteration on {A,Q,Q-1}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the controller decides when to register the result.
module alu_step_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  step_mode_t       mode,
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             q_m1_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out,
    output logic             q_m1_out
);

    logic [WIDTH:0]   m_sx;
    logic [WIDTH:0]   m_zx;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] q_sh;

    assign m_sx = {m_in[WIDTH-1], m_in};
    assign m_zx = {1'b0, m_in};

    // Booth: conditional add/sub then arithmetic shift right; divide: shift left then add/sub by sign of A
    always_comb begin
        sum      = a_in;
        a_sh     = a_in;
        q_sh     = q_in;
        a_out    = a_in;
        q_out    = q_in;
        q_m1_out = q_m1_in;
        if (mode == STEP_BOOTH) begin
            case ({q_in[0], q_m1_in})
                2'b01:   sum = a_in + m_sx;
                2'b10:   sum = a_in - m_sx;
                default: sum = a_in;
            endcase
            {a_out, q_out, q_m1_out} = {sum[WIDTH], sum, q_in};
        end else begin
            {a_sh, q_sh} = {a_in[WIDTH-1:0], q_in, 1'b0};
            if (!a_in[WIDTH]) begin
                sum = a_sh - m_zx;
            end else begin
                sum = a_sh + m_zx;
            end
            a_out = sum;
            q_out = {q_sh[WIDTH-1:1], ~sum[WIDTH]};
        end
    end

endmodule

// File: rtl/alu_seq_param.sv
// Sequential WIDTH-bit ALU: signed add/sub, Booth multiply, unsigned non-restoring divide.
// Latency: done in cycle 3 (add/sub, div by zero), WIDTH+3 (mul), WIDTH+4 (div).
// Backpressure: start is only accepted in IDLE; busy is high for every other state.
module alu_seq_param
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     inbus,
    input  logic [1:0]           op,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   outbus,
    output logic                 done,
    output logic                 busy,
    output logic                 ovf,
    output logic                 dz,
    output logic [2:0]           state,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     M
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         op_q;
    logic [WIDTH:0]     a_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   m_q;
    logic               q_m1_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] out_q;
    logic               ovf_q;
    logic               dz_q;

    logic [WIDTH:0]     step_a;
    logic [WIDTH-1:0]   step_q;
    logic               step_q_m1;
    step_mode_t         step_mode;
    logic               last_step;
    logic [WIDTH:0]     addsub_s;
    logic [WIDTH:0]     a_fix;

    assign step_mode = (state_q == S_DIV_STEP) ? STEP_DIV : STEP_BOOTH;
    // The counter reaches WIDTH after the final iteration; that extra cycle commits the result.
    assign last_step = (cnt_q == CW'(WIDTH));
    assign a_fix     = a_q[WIDTH] ? (a_q + {1'b0, m_q}) : a_q;
    assign addsub_s  = (op_q == OP_SUB) ? ({q_q[WIDTH-1], q_q} - {m_q[WIDTH-1], m_q})
                                        : ({q_q[WIDTH-1], q_q} + {m_q[WIDTH-1], m_q});

    alu_step_unit #(.WIDTH(WIDTH)) u_step (
        .mode     (step_mode),
        .a_in     (a_q),
        .q_in     (q_q),
        .q_m1_in  (q_m1_q),
        .m_in     (m_q),
        .a_out    (step_a),
        .q_out    (step_q),
        .q_m1_out (step_q_m1)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; divide-by-zero passes through DIV_FIX so it reports in the same cycle as add/sub
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_LOAD_Y;
            S_LOAD_Y: begin
                case (op_q)
                    OP_MUL:  state_d = S_MUL_STEP;
                    OP_DIV:  state_d = (inbus == '0) ? S_DIV_FIX : S_DIV_STEP;
                    default: state_d = S_ADDSUB;
                endcase
            end
            S_ADDSUB:   state_d = S_DONE;
            S_MUL_STEP: if (last_step) state_d = S_DONE;
            S_DIV_STEP: if (last_step) state_d = S_DIV_FIX;
            S_DIV_FIX:  state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath registers: operand capture, iteration and result/flag commit
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q   <= '0;
            a_q    <= '0;
            q_q    <= '0;
            m_q    <= '0;
            q_m1_q <= 1'b0;
            cnt_q  <= '0;
            out_q  <= '0;
            ovf_q  <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        q_q    <= inbus;
                        a_q    <= '0;
                        q_m1_q <= 1'b0;
                        cnt_q  <= '0;
                        ovf_q  <= 1'b0;
                        dz_q   <= 1'b0;
                    end
                end
                S_LOAD_Y: begin
                    m_q <= inbus;
                    if (op_q == OP_DIV && inbus == '0) begin
                        dz_q  <= 1'b1;
                        out_q <= {q_q, {WIDTH{1'b1}}};
                    end
                end
                S_ADDSUB: begin
                    out_q <= {{(WIDTH-1){addsub_s[WIDTH]}}, addsub_s};
                    ovf_q <= addsub_s[WIDTH] ^ addsub_s[WIDTH-1];
                end
                S_MUL_STEP, S_DIV_STEP: begin
                    if (last_step) begin
                        if (state_q == S_MUL_STEP) begin
                            out_q <= {a_q[WIDTH-1:0], q_q};
                        end
                    end else begin
                        a_q    <= step_a;
                        q_q    <= step_q;
                        q_m1_q <= step_q_m1;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                S_DIV_FIX: begin
                    if (!dz_q) begin
                        a_q   <= a_fix;
                        out_q <= {a_fix[WIDTH-1:0], q_q};
                    end
                end
                default: ;
            endcase
        end
    end

    assign outbus = out_q;
    assign ovf    = ovf_q;
    assign dz     = dz_q;
    assign done   = (state_q == S_DONE);
    assign busy   = (state_q != S_IDLE);
    assign state  = state_q;
    assign A      = a_q[WIDTH-1:0];
    assign Q      = q_q;
    assign M      = m_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Bench for alu_seq_param at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
// Latency: checks done arrives in exactly the expected cycle after start is sampled.
// Backpressure: exercises ignored starts while busy, mid-operation reset and back-to-back starts.
module tb_alu_seq_param;

    logic        clk;
    logic        rst;
    logic [1:0]  op;
    logic [7:0]  in8;
    logic [15:0] in16;
    logic        start8, start16;

    logic [15:0] out8;
    logic        done8, busy8, ovf8, dz8;
    logic [2:0]  state8;
    logic [7:0]  a8, q8, m8;

    logic [31:0] out16;
    logic        done16, busy16, ovf16, dz16;
    logic [2:0]  state16;
    logic [15:0] a16, q16, m16;

    int errors = 0;
    int checks = 0;

    logic        sel16 = 1'b0;
    logic [31:0] prev8 = '0;
    logic [31:0] prev16 = '0;

    alu_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .inbus(in8), .op(op), .start(start8),
        .outbus(out8), .done(done8), .busy(busy8), .ovf(ovf8), .dz(dz8),
        .state(state8), .A(a8), .Q(q8), .M(m8)
    );

    alu_seq_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .inbus(in16), .op(op), .start(start16),
        .outbus(out16), .done(done16), .busy(busy16), .ovf(ovf16), .dz(dz16),
        .state(state16), .A(a16), .Q(q16), .M(m16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] c_out;
    logic        c_done, c_busy, c_ovf, c_dz;
    logic [2:0]  c_state;
    assign c_out   = sel16 ? out16 : {16'h0, out8};
    assign c_done  = sel16 ? done16 : done8;
    assign c_busy  = sel16 ? busy16 : busy8;
    assign c_ovf   = sel16 ? ovf16 : ovf8;
    assign c_dz    = sel16 ? dz16 : dz8;
    assign c_state = sel16 ? state16 : state8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [15:0] v);
        start8  = s & ~sel16;
        start16 = s & sel16;
        in8     = v[7:0];
        in16    = v;
    endtask

    // Reference: plain integer arithmetic on the operands, independent of any register schedule
    task automatic model(input int w, input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         output logic [31:0] out, output logic ovf, output logic dz, output int lat);
        longint one = 1;
        longint ux = longint'(x) & ((one << w) - 1);
        longint uy = longint'(y) & ((one << w) - 1);
        longint sx = (ux >= (one << (w - 1))) ? ux - (one << w) : ux;
        longint sy = (uy >= (one << (w - 1))) ? uy - (one << w) : uy;
        longint mask = (one << (2 * w)) - 1;
        longint r;
        ovf = 1'b0;
        dz  = 1'b0;
        case (o)
            2'b00, 2'b01: begin
                r   = (o == 2'b00) ? sx + sy : sx - sy;
                ovf = (r > (one << (w - 1)) - 1) || (r < -(one << (w - 1)));
                lat = 3;
            end
            2'b10: begin
                r   = sx * sy;
                lat = w + 3;
            end
            default: begin
                if (uy == 0) begin
                    r   = (ux << w) | ((one << w) - 1);
                    dz  = 1'b1;
                    lat = 3;
                end else begin
                    r   = ((ux % uy) << w) | (ux / uy);
                    lat = w + 4;
                end
            end
        endcase
        out = 32'(r & mask);
    endtask

    // One operation: start in the current cycle, Y next cycle, then wait (bounded) for done
    task automatic run(input logic w16, input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       input int rst_at, input logic pulse);
        logic [31:0] e_out, prev;
        logic        e_ovf, e_dz;
        int          lat, k;
        logic        saw_done;
        sel16 = w16;
        model(w16 ? 16 : 8, o, x, y, e_out, e_ovf, e_dz, lat);
        prev = w16 ? prev16 : prev8;
        op = o;
        drive(1'b1, x);
        @(posedge clk); #1;
        chk("accept_state", 32'(c_state), 32'd1);
        chk("accept_ovf_clr", 32'(c_ovf), 32'd0);
        chk("accept_dz_clr", 32'(c_dz), 32'd0);
        chk("hold_outbus", c_out, prev);
        drive(1'b0, y);
        k = 1;
        forever begin
            if (rst_at == k) begin
                drive(1'b0, y);
                rst = 1'b0;
                @(posedge clk); #1;
                chk("rst_state", 32'(c_state), 32'd0);
                chk("rst_outbus", c_out, 32'd0);
                chk("rst_busy", 32'(c_busy), 32'd0);
                chk("rst_done", 32'(c_done), 32'd0);
                rst = 1'b1;
                saw_done = 1'b0;
                repeat (15) begin
                    @(posedge clk); #1;
                    saw_done = saw_done | done8 | done16;
                end
                chk("rst_no_done", 32'(saw_done), 32'd0);
                prev8  = '0;
                prev16 = '0;
                return;
            end
            if (c_done || k >= 60) break;
            chk("busy_in_op", 32'(c_busy), 32'd1);
            if (pulse && k >= 2 && k <= 4) begin
                op = 2'($urandom);
                drive(1'b1, 16'($urandom));
            end else if (pulse && k == 5) begin
                drive(1'b0, y);
            end
            @(posedge clk); #1;
            k++;
        end
        chk($sformatf("latency_op%0d_w%0d", o, w16 ? 16 : 8), 32'(k), 32'(lat));
        chk("done_busy", 32'(c_busy), 32'd1);
        chk($sformatf("outbus_op%0d_x%0h_y%0h", o, x, y), c_out, e_out);
        chk("ovf", 32'(c_ovf), 32'(e_ovf));
        chk("dz", 32'(c_dz), 32'(e_dz));
        if (w16) prev16 = e_out; else prev8 = e_out;
        @(posedge clk); #1;
        chk("done_pulse_end", 32'(c_done), 32'd0);
        chk("idle_after", 32'(c_state), 32'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [15:0] rx, ry;
        rst = 1'b0;
        op = 2'b00;
        start8 = 1'b0; start16 = 1'b0;
        in8 = '0; in16 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state8", 32'(state8), 32'd0);
        chk("reset_out8", 32'(out8), 32'd0);
        chk("reset_flags8", {28'd0, done8, busy8, ovf8, dz8}, 32'd0);
        chk("reset_aqm8", {8'd0, a8, q8, m8}, 32'd0);
        chk("reset_state16", 32'(state16), 32'd0);
        chk("reset_out16", out16, 32'd0);
        chk("reset_flags16", {28'd0, done16, busy16, ovf16, dz16}, 32'd0);
        chk("reset_aqm16", {16'd0, a16, q16}, 32'd0);
        chk("reset_m16", 32'(m16), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed WIDTH=8 cases, issued back-to-back
        run(1'b0, 2'b00, 16'd100, 16'd50, 0, 1'b0);
        run(1'b0, 2'b01, 16'd5, 16'd7, 0, 1'b0);
        run(1'b0, 2'b10, 16'h0080, 16'h0080, 0, 1'b0);
        run(1'b0, 2'b10, 16'd7, 16'h00FD, 0, 1'b1);
        run(1'b0, 2'b11, 16'd200, 16'd7, 0, 1'b0);
        run(1'b0, 2'b11, 16'd55, 16'd0, 0, 1'b0);
        run(1'b0, 2'b00, 16'h0080, 16'h00FF, 0, 1'b0);
        run(1'b0, 2'b11, 16'd3, 16'd250, 0, 1'b1);

        // Mid-multiply reset with ignored start pulses beforehand
        run(1'b0, 2'b10, 16'd9, 16'd11, 5, 1'b1);

        // Directed WIDTH=16 cases
        run(1'b1, 2'b10, 16'h7FFF, 16'h7FFF, 0, 1'b0);
        run(1'b1, 2'b11, 16'hFFFF, 16'h0010, 0, 1'b0);
        run(1'b1, 2'b01, 16'h8000, 16'h0001, 0, 1'b0);
        run(1'b1, 2'b10, 16'h8000, 16'h8000, 0, 1'b0);

        // Random operations on both widths
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom);
            rx = 16'($urandom);
            ry = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            run(1'(i % 2), ro, rx, ry, 0, 1'(i % 3 == 0 && ro[1]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
